iob_be_mem_ctrl: RTL and testbench

IOB_BE_MEM_CTRL -- requirements
Module: iob_be_mem_ctrl

---
 rtl/iob_be_mem_ctrl_pkg.sv | 19 +
 rtl/iob_reg_ca.sv | 20 ++
 rtl/iob_be_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_iob_be_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_be_mem_ctrl_pkg.sv
// Shared parameter defaults and FSM encoding for the IOb back-end memory controller.
package iob_be_mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 2;
    localparam int DEF_WR_LAT = 1;

    localparam int LAT_W  = 8;
    localparam int STAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/iob_reg_ca.sv
// Generic clock-enabled register with asynchronous active-high reset to zero.
module iob_reg_ca #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= '0;
        end else if (cke_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/iob_be_mem_ctrl.sv
// Latency-inserting bridge between the cache back-end IOb master and a byte-enable
// single-port RAM; one transaction in flight, completion counters for reads and writes.
module iob_be_mem_ctrl
    import iob_be_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic                mem_en_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_d_o,
    input  logic [DATA_W-1:0]   mem_d_i,
    output logic [STAT_W-1:0]   rd_cnt_o,
    output logic [STAT_W-1:0]   wr_cnt_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        r_state;
    state_t            w_state;
    state_t            w_stateNext;
    logic [LAT_W-1:0]  r_cnt;
    logic [LAT_W-1:0]  w_cntNext;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addrNext;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdataNext;
    logic [STRB_W-1:0] r_wstrb;
    logic [STRB_W-1:0] w_wstrbNext;
    logic [STAT_W-1:0] r_rdCnt;
    logic [STAT_W-1:0] w_rdCntNext;
    logic [STAT_W-1:0] r_wrCnt;
    logic [STAT_W-1:0] w_wrCntNext;
    logic              w_accept;
    logic [LAT_W-1:0]  w_lat;

    assign w_state  = state_t'(r_state);
    assign w_accept = iob_valid_i & iob_ready_o;
    assign w_lat    = (|iob_wstrb_i) ? LAT_W'(WR_LAT) : LAT_W'(RD_LAT);

    // RESP behaves as an idle cycle as well, so a new request overlaps the read response.
    always_comb begin
        w_stateNext = w_state;
        w_cntNext   = r_cnt;
        w_addrNext  = r_addr;
        w_wdataNext = r_wdata;
        w_wstrbNext = r_wstrb;
        w_rdCntNext = r_rdCnt;
        w_wrCntNext = r_wrCnt;
        case (w_state)
            ST_IDLE, ST_RESP: begin
                if (w_state == ST_RESP) begin
                    w_rdCntNext = r_rdCnt + STAT_W'(1);
                end
                w_stateNext = ST_IDLE;
                if (w_accept) begin
                    w_addrNext  = iob_addr_i;
                    w_wdataNext = iob_wdata_i;
                    w_wstrbNext = iob_wstrb_i;
                    w_cntNext   = w_lat;
                    w_stateNext = (w_lat != '0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                w_cntNext = r_cnt - LAT_W'(1);
                if (r_cnt <= LAT_W'(1)) begin
                    w_stateNext = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (|r_wstrb) begin
                    w_wrCntNext = r_wrCnt + STAT_W'(1);
                    w_stateNext = ST_IDLE;
                end else begin
                    w_stateNext = ST_RESP;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    iob_reg_ca #(.DATA_W(2)) u_state_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_stateNext), .data_o(r_state)
    );

    iob_reg_ca #(.DATA_W(LAT_W)) u_cnt_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_cntNext), .data_o(r_cnt)
    );

    iob_reg_ca #(.DATA_W(ADDR_W)) u_addr_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_addrNext), .data_o(r_addr)
    );

    iob_reg_ca #(.DATA_W(DATA_W)) u_wdata_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_wdataNext), .data_o(r_wdata)
    );

    iob_reg_ca #(.DATA_W(STRB_W)) u_wstrb_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_wstrbNext), .data_o(r_wstrb)
    );

    iob_reg_ca #(.DATA_W(STAT_W)) u_rd_cnt_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_rdCntNext), .data_o(r_rdCnt)
    );

    iob_reg_ca #(.DATA_W(STAT_W)) u_wr_cnt_reg (
        .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
        .data_i(w_wrCntNext), .data_o(r_wrCnt)
    );

    // The RAM must not see an enable while the controller is frozen; write enables follow it.
    assign mem_en_o     = (w_state == ST_ACCESS) & cke_i;
    assign mem_we_o     = mem_en_o ? r_wstrb : '0;
    assign mem_addr_o   = r_addr;
    assign mem_d_o      = r_wdata;
    assign iob_ready_o  = (w_state == ST_IDLE) || (w_state == ST_RESP);
    assign iob_rvalid_o = (w_state == ST_RESP);
    assign iob_rdata_o  = mem_d_i;
    assign rd_cnt_o     = r_rdCnt;
    assign wr_cnt_o     = r_wrCnt;

endmodule

// File: tb/tb_iob_be_mem_ctrl.sv
// Directed bench: dut (RD_LAT=2, WR_LAT=0) with a byte-enable RAM model,
// dut2 (RD_LAT=0, WR_LAT=3) with an address-echo RAM model.
`timescale 1ns/1ps
module tb_iob_be_mem_ctrl;

    logic        clk = 1'b0;
    logic        cke;
    logic        rst;
    logic        rst2;

    logic        valid;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        memEn;
    logic [3:0]  memWe;
    logic [23:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memQ;
    logic [31:0] rdCnt;
    logic [31:0] wrCnt;

    logic        valid2;
    logic [23:0] addr2;
    logic [31:0] wdata2;
    logic [3:0]  wstrb2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        ready2;
    logic        memEn2;
    logic [3:0]  memWe2;
    logic [23:0] memAddr2;
    logic [31:0] memWdata2;
    logic [31:0] memQ2;
    logic [31:0] rdCnt2;
    logic [31:0] wrCnt2;

    logic [31:0] ram [0:255];

    int testsRun = 0;
    int testsFailed = 0;

    int          enCount;
    int          enCycle;
    int          rvCount;
    int          rvCycle;
    int          rdyCycle;
    logic [3:0]  weAtEn;
    logic [23:0] addrAtEn;
    logic [31:0] dAtEn;
    logic [31:0] rdataAtRv;

    typedef struct {
        logic        isWrite;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] expData;
        int          expEn;
        int          expRdy;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    iob_be_mem_ctrl #(.ADDR_W(24), .DATA_W(32), .RD_LAT(2), .WR_LAT(0)) dut (
        .clk_i(clk), .cke_i(cke), .arst_i(rst),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rvalid_o(rvalid), .iob_rdata_o(rdata), .iob_ready_o(ready),
        .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_d_o(memWdata),
        .mem_d_i(memQ), .rd_cnt_o(rdCnt), .wr_cnt_o(wrCnt)
    );

    iob_be_mem_ctrl #(.ADDR_W(24), .DATA_W(32), .RD_LAT(0), .WR_LAT(3)) dut2 (
        .clk_i(clk), .cke_i(cke), .arst_i(rst2),
        .iob_valid_i(valid2), .iob_addr_i(addr2), .iob_wdata_i(wdata2), .iob_wstrb_i(wstrb2),
        .iob_rvalid_o(rvalid2), .iob_rdata_o(rdata2), .iob_ready_o(ready2),
        .mem_en_o(memEn2), .mem_we_o(memWe2), .mem_addr_o(memAddr2), .mem_d_o(memWdata2),
        .mem_d_i(memQ2), .rd_cnt_o(rdCnt2), .wr_cnt_o(wrCnt2)
    );

    // Read-first byte-enable RAM, preloaded while rst is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                ram[i] <= 32'h0;
            end
            ram[8'h04] <= 32'hAABBCCDD;
            ram[8'h10] <= 32'hCAFEBABE;
            ram[8'h3F] <= 32'h0BADF00D;
        end else if (memEn) begin
            memQ <= ram[memAddr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (memWe[b]) begin
                    ram[memAddr[7:0]][b*8 +: 8] <= memWdata[b*8 +: 8];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (memEn2) begin
            memQ2 <= {8'hA5, memAddr2};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One request on dut, then 16 monitored cycles; cycle n is n cycles after acceptance.
    task automatic applyStimulus(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input int ckeStart, input int ckeLen);
        enCount = 0; enCycle = -1; rvCount = 0; rvCycle = -1; rdyCycle = -1;
        weAtEn = '0; addrAtEn = '0; dAtEn = '0; rdataAtRv = '0;
        @(negedge clk);
        cke = 1'b1;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            valid = 1'b0;
            cke = !(n >= ckeStart && n < ckeStart + ckeLen);
            if (memEn) begin
                enCount++;
                if (enCycle < 0) begin
                    enCycle = n; weAtEn = memWe; addrAtEn = memAddr; dAtEn = memWdata;
                end
            end
            if (rvalid) begin
                rvCount++;
                if (rvCycle < 0) begin
                    rvCycle = n; rdataAtRv = rdata;
                end
            end
            if (ready && rdyCycle < 0) rdyCycle = n;
        end
        cke = 1'b1;
    endtask

    initial begin
        int expRd;
        int expWr;
        int k;
        int rvN;
        int en2N;
        int weSeen;
        int acc [4];
        int rvCyc2 [4];
        logic [31:0] rvData2 [4];
        logic [23:0] b2bAddr [4];

        vecs[0] = '{1'b0, 24'h10, 32'h0,        4'h0, 32'hCAFEBABE, 3, 4};
        vecs[1] = '{1'b1, 24'h04, 32'h12345678, 4'h3, 32'h0,        1, 2};
        vecs[2] = '{1'b0, 24'h04, 32'h0,        4'h0, 32'hAABB5678, 3, 4};
        vecs[3] = '{1'b1, 24'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1, 2};
        vecs[4] = '{1'b0, 24'h08, 32'h0,        4'h0, 32'hDEADBEEF, 3, 4};
        vecs[5] = '{1'b1, 24'h08, 32'h00AA0000, 4'h4, 32'h0,        1, 2};
        vecs[6] = '{1'b0, 24'h08, 32'h0,        4'h0, 32'hDEAABEEF, 3, 4};
        vecs[7] = '{1'b1, 24'h20, 32'h11223344, 4'h9, 32'h0,        1, 2};
        vecs[8] = '{1'b0, 24'h20, 32'h0,        4'h0, 32'h11000044, 3, 4};
        vecs[9] = '{1'b0, 24'h3F, 32'h0,        4'h0, 32'h0BADF00D, 3, 4};
        b2bAddr[0] = 24'h000100; b2bAddr[1] = 24'h000200;
        b2bAddr[2] = 24'hABCDEF; b2bAddr[3] = 24'hFFFFFF;

        cke = 1'b1; rst = 1'b1; rst2 = 1'b1;
        valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        valid2 = 1'b0; addr2 = '0; wdata2 = '0; wstrb2 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset mem_en", 32'(memEn), 32'd0);
        checkOutput("reset mem_we", 32'(memWe), 32'd0);
        checkOutput("reset rd_cnt", rdCnt, 32'd0);
        checkOutput("reset wr_cnt", wrCnt, 32'd0);
        rst = 1'b0; rst2 = 1'b0;

        expRd = 0; expWr = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0);
            checkOutput($sformatf("v%0d en count", i), enCount, 32'd1);
            checkOutput($sformatf("v%0d en cycle", i), enCycle, vecs[i].expEn);
            checkOutput($sformatf("v%0d mem addr", i), {8'h0, addrAtEn}, {8'h0, vecs[i].addr});
            checkOutput($sformatf("v%0d mem we", i), 32'(weAtEn), 32'(vecs[i].wstrb));
            checkOutput($sformatf("v%0d ready cycle", i), rdyCycle, vecs[i].expRdy);
            checkOutput($sformatf("v%0d rvalid count", i), rvCount, vecs[i].isWrite ? 32'd0 : 32'd1);
            if (vecs[i].isWrite) begin
                expWr++;
                checkOutput($sformatf("v%0d mem d", i), dAtEn, vecs[i].wdata);
            end else begin
                expRd++;
                checkOutput($sformatf("v%0d rvalid cycle", i), rvCycle, vecs[i].expRdy);
                checkOutput($sformatf("v%0d rdata", i), rdataAtRv, vecs[i].expData);
            end
        end
        checkOutput("table rd_cnt", rdCnt, expRd);
        checkOutput("table wr_cnt", wrCnt, expWr);

        // cke low for cycles 1..3 of a RD_LAT=2 read pushes access to 6 and rvalid to 7.
        applyStimulus(24'h10, 32'h0, 4'h0, 1, 3);
        checkOutput("cke en count", enCount, 32'd1);
        checkOutput("cke en cycle", enCycle, 32'd6);
        checkOutput("cke rvalid cycle", rvCycle, 32'd7);
        checkOutput("cke ready cycle", rdyCycle, 32'd7);
        checkOutput("cke rdata", rdataAtRv, 32'hCAFEBABE);
        expRd++;
        checkOutput("cke rd_cnt", rdCnt, expRd);

        // Read counter wrap.
        @(negedge clk);
        force dut.u_rd_cnt_reg.data_o = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.u_rd_cnt_reg.data_o;
        @(negedge clk);
        checkOutput("preload rd_cnt", rdCnt, 32'hFFFFFFFF);
        applyStimulus(24'h10, 32'h0, 4'h0, 0, 0);
        checkOutput("wrap rd_cnt", rdCnt, 32'd0);
        checkOutput("wrap wr_cnt", wrCnt, expWr);
        checkOutput("wrap rdata", rdataAtRv, 32'hCAFEBABE);

        // dut2: valid held high for four reads with RD_LAT=0.
        k = 0; rvN = 0; en2N = 0;
        for (int n = 0; n <= 12; n++) begin
            @(negedge clk);
            if (rvalid2) begin
                if (rvN < 4) begin
                    rvCyc2[rvN] = n; rvData2[rvN] = rdata2;
                end
                rvN++;
            end
            if (memEn2) en2N++;
            if (k < 4) begin
                valid2 = 1'b1; addr2 = b2bAddr[k]; wstrb2 = 4'h0;
                if (ready2) begin
                    acc[k] = n; k++;
                end
            end else begin
                valid2 = 1'b0;
            end
        end
        valid2 = 1'b0;
        checkOutput("b2b accepted", k, 32'd4);
        checkOutput("b2b rvalid count", rvN, 32'd4);
        checkOutput("b2b en count", en2N, 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < k) checkOutput($sformatf("b2b accept %0d", j), acc[j], 2 * j);
            if (j < rvN) begin
                checkOutput($sformatf("b2b rvalid %0d", j), rvCyc2[j], 2 * j + 2);
                checkOutput($sformatf("b2b data %0d", j), rvData2[j], {8'hA5, b2bAddr[j]});
            end
        end
        checkOutput("b2b rd_cnt", rdCnt2, 32'd4);

        // dut2: reset pulse while a WR_LAT=3 write is waiting.
        @(negedge clk);
        valid2 = 1'b1; addr2 = 24'h5; wdata2 = 32'h55AA55AA; wstrb2 = 4'hF;
        weSeen = 0; en2N = 0; rvN = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            valid2 = 1'b0;
            if (n == 2) rst2 = 1'b1;
            if (n == 4) rst2 = 1'b0;
            if (n == 3) checkOutput("abort rd_cnt in reset", rdCnt2, 32'd0);
            if (memWe2 != 4'h0) weSeen++;
            if (memEn2) en2N++;
            if (rvalid2) rvN++;
        end
        checkOutput("abort we seen", weSeen, 32'd0);
        checkOutput("abort en count", en2N, 32'd0);
        checkOutput("abort rvalid count", rvN, 32'd0);
        checkOutput("abort ready", 32'(ready2), 32'd1);
        checkOutput("abort wr_cnt", wrCnt2, 32'd0);
        checkOutput("abort rd_cnt", rdCnt2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
